// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: clear-engine state encoding,
// legal read-latency bounds and the byte-lane merge used by port A writes
// and by write-first collision forwarding to port B.
// No ports (package).
package ram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Merge is written once at a generous fixed width; callers zero-extend
  // their operands in and truncate the result back to DATA_W.
  localparam int MERGE_W = 512;
  localparam int MBE_W   = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0] old_word,
    input logic [MERGE_W-1:0] new_word,
    input logic [MBE_W-1:0]   be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MBE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_if.sv
// Bus bundle for ram_dp: port A (read/write, byte enables), port B
// (read-only) and the clear-engine busy flag.
// Modports: master (requester side), slave (memory side).
interface ram_dp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                init_busy;
  logic                a_req;
  logic                a_we;
  logic [DATA_W/8-1:0] a_be;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_wdata;
  logic [DATA_W-1:0]   a_rdata;
  logic                a_ack;
  logic                b_req;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_rdata;
  logic                b_ack;

  modport master (
    input  init_busy, a_rdata, a_ack, b_rdata, b_ack,
    output a_req, a_we, a_be, a_addr, a_wdata, b_req, b_addr
  );

  modport slave (
    output init_busy, a_rdata, a_ack, b_rdata, b_ack,
    input  a_req, a_we, a_be, a_addr, a_wdata, b_req, b_addr
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Per-port read delay line carrying {ack, data}.
// Ports: clk, reset (sync, active-high), vld_in/data_in (array read result
// on the accepting edge), ack (one-cycle completion pulse), rdata (holds
// the last completed read).
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage p0: array read register; data only loads on a valid read so the
  // output holds between completions.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= vld_in;
      if (vld_in) data_p0 <= data_in;
    end
  end

  generate
    if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;

      // Stage p1: optional output register.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign ack   = vld_p1;
      assign rdata = data_p1;
    end else begin : g_lat1
      assign ack   = vld_p0;
      assign rdata = data_p0;
    end
  endgenerate

endmodule

// File: rtl/ram_dp.sv
// Dual-port synchronous RAM. Port A reads/writes with byte enables, port B
// is read-only. A sequential clear engine writes INIT_VAL to every word
// after reset; requests are dropped while init_busy is high.
// Ports: clk, reset (sync, active-high, restarts the clear), bus (slave
// side of ram_dp_if: init_busy, port A and port B signals).
module ram_dp
  import ram_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 8,
  parameter int                DEPTH       = 128,
  parameter int                RD_LAT      = 1,
  parameter int                WRITE_FIRST = 0,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0
) (
  input logic     clk,
  input logic     reset,
  ram_dp_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT   = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_n;
  logic [IDX_W-1:0]  cnt_q, cnt_n;
  logic              clr_we;

  logic              a_acc, a_in, a_wr, a_rd;
  logic              b_acc, b_in, b_hit;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic [DATA_W-1:0] a_old, a_merged, a_rd_data, b_old, b_rd_data;
  logic              wack_p0, a_rd_ack;

  // Clear engine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = ~reset;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_n = READY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.init_busy = (state_q == CLEAR);

  // Request acceptance and address decode
  assign a_acc = bus.a_req & ~bus.init_busy & ~reset;
  assign b_acc = bus.b_req & ~bus.init_busy & ~reset;
  assign a_wr  = a_acc & bus.a_we;
  assign a_rd  = a_acc & ~bus.a_we;
  assign a_in  = 32'(bus.a_addr) < DEPTH;
  assign b_in  = 32'(bus.b_addr) < DEPTH;
  assign a_idx = bus.a_addr[IDX_W-1:0];
  assign b_idx = bus.b_addr[IDX_W-1:0];

  assign a_old    = mem[a_idx];
  assign b_old    = mem[b_idx];
  assign a_merged = DATA_W'(be_merge(MERGE_W'(a_old), MERGE_W'(bus.a_wdata),
                                     MBE_W'(bus.a_be)));

  // Write-first forwarding: same in-range word, so a_merged is exactly the
  // old B word with the new lanes applied.
  assign b_hit = (WRITE_FIRST != 0) && a_wr && a_in && (bus.a_addr == bus.b_addr);

  assign a_rd_data = a_in ? a_old : '0;
  assign b_rd_data = !b_in ? '0 : (b_hit ? a_merged : b_old);

  // Array write port; the clear engine only runs while requests are blocked.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (a_wr && a_in) begin
      mem[a_idx] <= a_merged;
    end
  end

  // Write ack always returns one cycle after acceptance, independent of RD_LAT.
  always_ff @(posedge clk) begin
    if (reset) wack_p0 <= 1'b0;
    else       wack_p0 <= a_wr;
  end

  ram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_pipe_a (
    .clk     (clk),
    .reset   (reset),
    .vld_in  (a_rd),
    .data_in (a_rd_data),
    .ack     (a_rd_ack),
    .rdata   (bus.a_rdata)
  );

  ram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(LAT)) u_pipe_b (
    .clk     (clk),
    .reset   (reset),
    .vld_in  (b_acc),
    .data_in (b_rd_data),
    .ack     (bus.b_ack),
    .rdata   (bus.b_rdata)
  );

  assign bus.a_ack = wack_p0 | a_rd_ack;

endmodule

// File: tb/tb_ram_dp.sv
// Testbench for ram_dp. Two instances share one stimulus stream:
// dut1 = RD_LAT 1 / read-old collision, dut2 = RD_LAT 2 / write-first.
// Expected read data and completion cycle are queued per port when a
// request is driven and compared when the ack arrives.
module tb_ram_dp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_req, a_we, b_req;
  logic [1:0]  a_be;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata;

  ram_dp_if #(.DATA_W(16), .ADDR_W(8)) if1 ();
  ram_dp_if #(.DATA_W(16), .ADDR_W(8)) if2 ();

  assign if1.a_req = a_req;   assign if2.a_req = a_req;
  assign if1.a_we = a_we;     assign if2.a_we = a_we;
  assign if1.a_be = a_be;     assign if2.a_be = a_be;
  assign if1.a_addr = a_addr; assign if2.a_addr = a_addr;
  assign if1.a_wdata = a_wdata; assign if2.a_wdata = a_wdata;
  assign if1.b_req = b_req;   assign if2.b_req = b_req;
  assign if1.b_addr = b_addr; assign if2.b_addr = b_addr;

  ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .RD_LAT(1), .WRITE_FIRST(0),
           .INIT_VAL(16'hA5A5)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  ram_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .RD_LAT(2), .WRITE_FIRST(1),
           .INIT_VAL(16'hA5A5)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb [4][$];   // 0:dut1 A, 1:dut1 B, 2:dut2 A, 3:dut2 B
  logic [15:0] mdl [128];
  logic [15:0] last_rd [4];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  logic        ack_o [4];
  logic [15:0] dat_o [4];
  assign ack_o[0] = if1.a_ack; assign dat_o[0] = if1.a_rdata;
  assign ack_o[1] = if1.b_ack; assign dat_o[1] = if1.b_rdata;
  assign ack_o[2] = if2.a_ack; assign dat_o[2] = if2.a_rdata;
  assign ack_o[3] = if2.b_ack; assign dat_o[3] = if2.b_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdl_rd(input logic [7:0] addr);
    return (int'(addr) < 128) ? mdl[addr] : 16'h0000;
  endfunction

  function automatic logic [15:0] lane_mix(input logic [15:0] old_w,
                                           input logic [15:0] new_w,
                                           input logic [1:0]  be);
    logic [15:0] mask;
    mask = {{8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Scoreboard: each ack pops one expectation, data and cycle must match.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (ack_o[k] === 1'b1) begin
        n_assert++;
        if (sb[k].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack port%0d: ack=1 at cycle %0d, required no ack", k, cyc);
        end else begin
          e = sb[k].pop_front();
          if (dat_o[k] !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL read_ack port%0d: data=%h cycle=%0d, required data=%h cycle=%0d",
                     k, dat_o[k], cyc, e.data, e.due);
          end
        end
      end else if (sb[k].size() != 0 && sb[k][0].due < cyc) begin
        n_assert++;
        n_fail++;
        $display("FAIL missing_ack port%0d: no ack by cycle %0d, required ack at cycle %0d",
                 k, cyc, sb[k][0].due);
        void'(sb[k].pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request cycle; en says whether the RAM should accept it.
  task automatic drive(input bit en, input logic ar, input logic awe,
                       input logic [1:0] abe, input logic [7:0] aaddr,
                       input logic [15:0] awd, input logic br,
                       input logic [7:0] baddr);
    exp_t e;
    int   lt;
    a_req = ar; a_we = awe; a_be = abe; a_addr = aaddr; a_wdata = awd;
    b_req = br; b_addr = baddr;
    if (en) begin
      for (int d = 0; d < 2; d++) begin
        lt = (d == 0) ? 1 : 2;
        if (br) begin
          e.data = mdl_rd(baddr);
          if (d == 1 && ar && awe && aaddr == baddr && int'(baddr) < 128)
            e.data = lane_mix(e.data, awd, abe);
          e.due = cyc + lt;
          sb[d*2+1].push_back(e);
        end
        if (ar && !awe) begin
          e.data = mdl_rd(aaddr);
          e.due  = cyc + lt;
          last_rd[d*2] = e.data;
          sb[d*2].push_back(e);
        end
        if (ar && awe) begin
          e.data = last_rd[d*2];
          e.due  = cyc + 1;
          sb[d*2].push_back(e);
        end
      end
      if (ar && awe && int'(aaddr) < 128) mdl[aaddr] = lane_mix(mdl[aaddr], awd, abe);
    end
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Counts busy cycles of each instance and acks seen while clearing.
  task automatic count_clear(output int b1, output int b2, output int acks);
    b1 = 0; b2 = 0; acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (if1.init_busy !== 1'b1 && if2.init_busy !== 1'b1) break;
      if (if1.init_busy === 1'b1) b1++;
      if (if2.init_busy === 1'b1) b2++;
      for (int k = 0; k < 4; k++) if (ack_o[k] === 1'b1) acks++;
    end
    for (int i = 0; i < 128; i++) mdl[i] = 16'hA5A5;
    for (int k = 0; k < 4; k++) last_rd[k] = 16'h0000;
  endtask

  task automatic test_reset;
    int b1, b2, acks;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;
    @(posedge clk);
    #1;
    n_assert++;
    if (if1.init_busy !== 1'b1 || if2.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%b/%b, required 1/1", if1.init_busy, if2.init_busy);
    end
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (ack_o[k] !== 1'b0 || dat_o[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_out port%0d: ack=%b rdata=%h, required ack=0 rdata=0000",
                 k, ack_o[k], dat_o[k]);
      end
    end
    reset = 1'b0;
    // Requests during the clear must be dropped.
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd3; b_req = 1'b1; b_addr = 8'd4;
    count_clear(b1, b2, acks);
    a_req = 1'b0; b_req = 1'b0;
    n_assert++;
    if (b1 != 128 || b2 != 128) begin
      n_fail++;
      $display("FAIL clear_len: busy cycles=%0d/%0d, required 128", b1, b2);
    end
    n_assert++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL busy_drop: acks during clear=%0d, required 0", acks);
    end
  endtask

  task automatic test_clear_values;
    drive(1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 8'd0, 16'h0, 1'b1, 8'd64);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd100, 16'h0, 1'b1, 8'd127);
    idle(4);
  endtask

  task automatic test_byte_enable;
    drive(1, 1'b1, 1'b1, 2'b11, 8'd5, 16'h1234, 1'b0, 8'd0);
    drive(1, 1'b1, 1'b1, 2'b10, 8'd5, 16'hABCD, 1'b0, 8'd0);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd5, 16'h0000, 1'b0, 8'd0);
    idle(4);
  endtask

  task automatic test_back_to_back;
    drive(1, 1'b1, 1'b1, 2'b11, 8'd1, 16'h0011, 1'b0, 8'd0);
    drive(1, 1'b1, 1'b1, 2'b11, 8'd2, 16'h0022, 1'b0, 8'd0);
    drive(1, 1'b1, 1'b1, 2'b11, 8'd3, 16'h0033, 1'b0, 8'd0);
    idle(3);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd3, 16'h0, 1'b1, 8'd1);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd2, 16'h0, 1'b1, 8'd2);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd1, 16'h0, 1'b1, 8'd3);
    idle(4);
  endtask

  task automatic test_collision;
    drive(1, 1'b1, 1'b1, 2'b11, 8'd9, 16'h0000, 1'b0, 8'd0);
    idle(2);
    drive(1, 1'b1, 1'b1, 2'b01, 8'd9, 16'hFFFF, 1'b1, 8'd9);
    idle(3);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd9, 16'h0, 1'b0, 8'd0);
    idle(4);
  endtask

  task automatic test_out_of_range;
    drive(1, 1'b1, 1'b1, 2'b11, 8'd200, 16'h7777, 1'b1, 8'd200);
    idle(2);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd200, 16'h0, 1'b1, 8'd255);
    drive(1, 1'b1, 1'b0, 2'b00, 8'd72, 16'h0, 1'b0, 8'd0);
    idle(4);
  endtask

  task automatic test_reset_mid_clear;
    int b1, b2, acks;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(50);
    n_assert++;
    if (if1.init_busy !== 1'b1 || if2.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_clear_busy: busy=%b/%b, required 1/1", if1.init_busy, if2.init_busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_clear(b1, b2, acks);
    n_assert++;
    if (b1 != 128 || b2 != 128) begin
      n_fail++;
      $display("FAIL restart_len: busy cycles=%0d/%0d, required 128", b1, b2);
    end
    for (int i = 0; i < 128; i++)
      drive(1, 1'b1, 1'b0, 2'b00, 8'(i), 16'h0, 1'b1, 8'(127 - i));
    idle(4);
  endtask

  initial begin
    test_reset();
    test_clear_values();
    test_byte_enable();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid_clear();
    idle(4);
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain port%0d: %0d reads outstanding, required 0", k, sb[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
Name: ram_dp

Overview:
Parametrised dual-port synchronous RAM, the next generation of the core's data/instruction memory. Port A is read/write with byte enables. Port B is read-only, intended for instruction fetch. Adds configurable read latency, a defined read-during-write collision mode, and a sequential clear engine that replaces the single-cycle whole-array reset.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8
ADDR_W, 8, address width in bits
DEPTH, 128, number of words; must be <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values are 1 or 2
WRITE_FIRST, 0, port B view of a same-cycle port A write: 1 = new data, 0 = old data
INIT_VAL, 0, DATA_W-wide value written to every word during clear

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high; starts the clear sequence
init_busy  out  1  high while the clear sequence runs; requests are ignored while high
a_req  in  1  port A request strobe, single cycle
a_we  in  1  port A: 1 = write, 0 = read
a_be  in  DATA_W/8  port A byte-lane write enables
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_rdata  out  DATA_W  port A read data
a_ack  out  1  port A completion pulse
b_req  in  1  port B read request strobe
b_addr  in  ADDR_W  port B word address
b_rdata  out  DATA_W  port B read data
b_ack  out  1  port B completion pulse

Behaviour:
- Reset values: init_busy=1, a_ack=0, b_ack=0, a_rdata=0, b_rdata=0, clear counter=0, FSM=CLEAR.
- FSM CLEAR:
  - Each cycle after reset deasserts, write INIT_VAL to mem[cnt], then cnt++.
  - After the write to DEPTH-1, go to READY; init_busy falls on the same edge.
  - Total: exactly DEPTH cycles after the reset-low edge.
- FSM READY: serve requests. Reset asserted in any state (including mid-clear) returns to CLEAR with cnt=0.
- Acceptance: a request is accepted iff req=1 and init_busy=0. Requests made during CLEAR are dropped and never acked.
- Port A write:
  - mem[a_addr] byte lane i updated iff a_be[i] on the accepting edge.
  - a_ack pulses 1 cycle later; a_rdata unchanged.
- Reads (port A with a_we=0, or port B):
  - rdata and ack are valid together exactly RD_LAT cycles after acceptance.
  - rdata holds its value until the next read completion on that port.
  - ack is a one-cycle pulse per request.
  - Back-to-back requests every cycle are fully pipelined, with one ack per request and in order.
- Out of range (addr >= DEPTH): writes are discarded, reads return 0, ack is still generated with normal timing.
- Collision (A write and B read to the same address, same cycle):
  - WRITE_FIRST=1: B returns the old word merged with the new bytes selected by a_be.
  - WRITE_FIRST=0: B returns the pre-write word.
  - Port A's own write never disturbs a read in flight.
- Simultaneous A and B reads, including to the same address: both are served independently. There is no arbitration and no stall.
- RD_LAT=2 adds one register stage after the array read for both data and ack. It applies to both ports.

Decomposition:
- Shared package ram_pkg holds:
  - the state typedef {CLEAR, READY}
  - RD_LAT_MIN=1, RD_LAT_MAX=2
  - a function for byte-enable merge
- One sub-module: ram_rd_pipe, the per-port delay line carrying {ack, data}.
  - Parametrised by DATA_W and RD_LAT.
  - Instantiated twice.

Test Plan:
- Clear: DEPTH=128, INIT_VAL=16'hA5A5; pulse reset for 1 cycle -> init_busy high for exactly 128 cycles. Then B reads addresses 0, 64, 127 -> each returns A5A5; a_req during busy -> no a_ack.
- Byte enables: A writes 16'h1234 to addr 5 with be=2'b11, then 16'hABCD with be=2'b10. A reads addr 5 -> 16'hAB34, ack RD_LAT cycles after request.
- Latency/pipelining: RD_LAT=2; B reads addresses 1, 2, 3 on consecutive cycles (preloaded 11, 22, 33) -> b_ack high on 3 consecutive cycles starting 2 cycles after the first request, data 11, 22, 33 in order.
- Collision: mem[9]=16'h0000; A writes 16'hFFFF with be=2'b01 while B reads 9 in the same cycle -> WRITE_FIRST=1 gives 16'h00FF; WRITE_FIRST=0 gives 16'h0000.
- Out of range: DEPTH=128, A writes 16'h7777 to addr 200 -> a_ack pulses once. A reads 200 -> 0, and addr 72 (200 mod 128) is unchanged.
- Reset mid-clear: assert reset at clear cycle 50 -> counter restarts; init_busy stays high for 128 more cycles; all words read INIT_VAL.
